// File: rtl/btb_write_scheduler.sv
// btb_write_scheduler
//   Arbitrates the single BTB write port between EX-stage resolve updates and
//   whole-table invalidate sweeps. A sweep runs automatically after reset and
//   on i_inval_req. Updates that arrive during a sweep are buffered in a small
//   FIFO and drained once the sweep completes. Prediction use is gated while
//   the table is being cleared.
// Ports
//   i_clk, i_rst             clock (rising edge), synchronous active-high reset
//   i_upd_valid/idx/data     update request; accepted when valid & o_upd_ready
//   o_upd_ready              FIFO has room (combinational from the FIFO count)
//   o_upd_drop               1-cycle pulse: an accepted update was discarded
//   i_inval_req              request a full-table invalidate
//   o_inval_busy             sweep in progress
//   o_inval_done             1-cycle pulse on the first idle cycle after a sweep
//   o_pred_en                BTB contents usable for prediction
//   o_wr_en/idx/data         registered BTB write port
module btb_write_scheduler #(
  parameter int unsigned IDX_W  = 11,
  parameter int unsigned DATA_W = 17,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_upd_valid,
  input  logic [IDX_W-1:0]  i_upd_idx,
  input  logic [DATA_W-1:0] i_upd_data,
  output logic              o_upd_ready,
  output logic              o_upd_drop,
  input  logic              i_inval_req,
  output logic              o_inval_busy,
  output logic              o_inval_done,
  output logic              o_pred_en,
  output logic              o_wr_en,
  output logic [IDX_W-1:0]  o_wr_idx,
  output logic [DATA_W-1:0] o_wr_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  sweep_cnt_q, sweep_cnt_d;
  // Set once the last index has been written; the following SWEEP cycle
  // issues no write and hands over to IDLE.
  logic              sweep_wrap_q, sweep_wrap_d;

  entry_t            fifo_mem_q [DEPTH];
  entry_t            fifo_mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;

  logic              wr_en_q, wr_en_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              inval_done_q, inval_done_d;
  logic              upd_drop_q, upd_drop_d;
  logic              pred_en_q, pred_en_d;

  logic              upd_acc;
  logic              fifo_empty;
  logic              do_enq;
  logic              do_deq;
  logic              do_flush;
  entry_t            head;
  entry_t            new_entry;

  assign o_upd_ready  = (count_q < DEPTH_C);
  assign upd_acc      = i_upd_valid && o_upd_ready;
  assign fifo_empty   = (count_q == '0);
  assign head         = fifo_mem_q[rd_ptr_q];
  assign new_entry    = '{idx: i_upd_idx, data: i_upd_data};

  always_comb begin
    state_d      = state_q;
    sweep_cnt_d  = sweep_cnt_q;
    sweep_wrap_d = sweep_wrap_q;
    wr_en_d      = 1'b0;
    wr_idx_d     = wr_idx_q;
    wr_data_d    = wr_data_q;
    inval_done_d = 1'b0;
    upd_drop_d   = 1'b0;
    do_enq       = 1'b0;
    do_deq       = 1'b0;
    do_flush     = 1'b0;

    if (state_q == ST_SWEEP) begin
      // Updates are buffered for the whole sweep; a new invalidate request
      // is absorbed by the sweep already running.
      do_enq = upd_acc;
      if (sweep_wrap_q) begin
        state_d      = ST_IDLE;
        sweep_wrap_d = 1'b0;
        inval_done_d = 1'b1;
      end else begin
        wr_en_d     = 1'b1;
        wr_idx_d    = sweep_cnt_q;
        wr_data_d   = '0;
        sweep_cnt_d = sweep_cnt_q + 1'b1;
        if (sweep_cnt_q == '1) begin
          sweep_wrap_d = 1'b1;
        end
      end
    end else begin
      if (i_inval_req) begin
        state_d      = ST_SWEEP;
        sweep_cnt_d  = '0;
        sweep_wrap_d = 1'b0;
        do_flush     = 1'b1;
        upd_drop_d   = upd_acc;
      end else if (!fifo_empty) begin
        do_deq    = 1'b1;
        do_enq    = upd_acc;
        wr_en_d   = 1'b1;
        wr_idx_d  = head.idx;
        wr_data_d = head.data;
      end else if (upd_acc) begin
        wr_en_d   = 1'b1;
        wr_idx_d  = i_upd_idx;
        wr_data_d = i_upd_data;
      end
    end

    pred_en_d = (state_d == ST_IDLE);
  end

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (do_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_enq) begin
        fifo_mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (do_deq) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_enq, do_deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_SWEEP;
      sweep_cnt_q  <= '0;
      sweep_wrap_q <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_idx_q     <= '0;
      wr_data_q    <= '0;
      inval_done_q <= 1'b0;
      upd_drop_q   <= 1'b0;
      pred_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_cnt_q  <= sweep_cnt_d;
      sweep_wrap_q <= sweep_wrap_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      wr_en_q      <= wr_en_d;
      wr_idx_q     <= wr_idx_d;
      wr_data_q    <= wr_data_d;
      inval_done_q <= inval_done_d;
      upd_drop_q   <= upd_drop_d;
      pred_en_q    <= pred_en_d;
    end
  end

  // Storage only; validity is tracked by the pointers and count.
  always_ff @(posedge i_clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign o_inval_busy = (state_q == ST_SWEEP);
  assign o_inval_done = inval_done_q;
  assign o_upd_drop   = upd_drop_q;
  assign o_pred_en    = pred_en_q;
  assign o_wr_en      = wr_en_q;
  assign o_wr_idx     = wr_idx_q;
  assign o_wr_data    = wr_data_q;

endmodule

// File: tb/tb_btb_write_scheduler.sv
module tb_btb_write_scheduler;

  localparam int IDX_W  = 3;
  localparam int DATA_W = 17;
  localparam int DEPTH  = 4;
  localparam int N      = 1 << IDX_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic [DATA_W-1:0] upd_data;
  logic              upd_ready;
  logic              upd_drop;
  logic              inval_req;
  logic              inval_busy;
  logic              inval_done;
  logic              pred_en;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  always #5 clk = ~clk;

  btb_write_scheduler #(.IDX_W(IDX_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_upd_valid  (upd_valid),
    .i_upd_idx    (upd_idx),
    .i_upd_data   (upd_data),
    .o_upd_ready  (upd_ready),
    .o_upd_drop   (upd_drop),
    .i_inval_req  (inval_req),
    .o_inval_busy (inval_busy),
    .o_inval_done (inval_done),
    .o_pred_en    (pred_en),
    .o_wr_en      (wr_en),
    .o_wr_idx     (wr_idx),
    .o_wr_data    (wr_data)
  );

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } upd_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a sweep is N zero-writes followed by one hand-over cycle; when
  // idle, accepted updates join the pending queue and the oldest pending one
  // is written every cycle.
  bit                m_init = 1'b0;
  bit                m_busy;
  int                m_pos;
  upd_t              m_q[$];
  logic              m_wr_en, m_done, m_drop;
  logic [IDX_W-1:0]  m_wr_idx;
  logic [DATA_W-1:0] m_wr_data;
  int                cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_busy = 1'b1; m_pos = 0; m_q.delete();
      m_wr_en = 1'b0; m_wr_idx = '0; m_wr_data = '0;
      m_done = 1'b0; m_drop = 1'b0; m_init = 1'b1;
    end else if (m_init) begin
      bit acc;
      upd_t e;
      acc = upd_valid && (m_q.size() < DEPTH);
      m_wr_en = 1'b0; m_done = 1'b0; m_drop = 1'b0;
      if (m_busy) begin
        if (acc) m_q.push_back('{idx: upd_idx, data: upd_data});
        if (m_pos < N) begin
          m_wr_en = 1'b1; m_wr_idx = IDX_W'(m_pos); m_wr_data = '0; m_pos++;
        end else begin
          m_busy = 1'b0; m_done = 1'b1; m_pos = 0;
        end
      end else if (inval_req) begin
        m_q.delete(); m_drop = acc; m_busy = 1'b1; m_pos = 0;
      end else begin
        if (acc) m_q.push_back('{idx: upd_idx, data: upd_data});
        if (m_q.size() > 0) begin
          e = m_q.pop_front();
          m_wr_en = 1'b1; m_wr_idx = e.idx; m_wr_data = e.data;
        end
      end
    end
  end

  // Per-cycle compare plus a log of data writes, done pulses and zero writes.
  upd_t log_q[$];
  int   log_cyc[$];
  int   n_done = 0;
  int   n_zero = 0;
  int   last_done_cyc = 0;

  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("wr_en",      32'(wr_en),      32'(m_wr_en));
      chk("wr_idx",     32'(wr_idx),     32'(m_wr_idx));
      chk("wr_data",    32'(wr_data),    32'(m_wr_data));
      chk("upd_ready",  32'(upd_ready),  32'(m_q.size() < DEPTH));
      chk("inval_busy", 32'(inval_busy), 32'(m_busy));
      chk("pred_en",    32'(pred_en),    32'(!m_busy));
      chk("inval_done", 32'(inval_done), 32'(m_done));
      chk("upd_drop",   32'(upd_drop),   32'(m_drop));
    end
    if (wr_en === 1'b1 && wr_data !== '0) begin
      log_q.push_back('{idx: wr_idx, data: wr_data});
      log_cyc.push_back(cyc);
    end
    if (wr_en === 1'b1 && wr_data === '0) n_zero++;
    if (inval_done === 1'b1) begin
      n_done++;
      last_done_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (inval_done !== 1'b1 && k < 40) begin step(); k++; end
    chk(nm, 32'(inval_done), 32'd1);
  endtask

  task automatic wait_wr_idx(input string nm, input logic [IDX_W-1:0] target);
    int k = 0;
    while (!(wr_en === 1'b1 && wr_idx === target) && k < 40) begin step(); k++; end
    chk(nm, 32'(wr_idx), 32'(target));
  endtask

  task automatic send(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] data);
    upd_valid = 1'b1; upd_idx = idx; upd_data = data;
    step();
    upd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base, bdone, bzero, k;
    rst = 1'b1; upd_valid = 1'b0; upd_idx = '0; upd_data = '0; inval_req = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_idx", 32'(wr_idx), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_busy", 32'(inval_busy), 1);
    chk("rst_pred", 32'(pred_en), 0);
    chk("rst_ready", 32'(upd_ready), 1);
    chk("rst_drop", 32'(upd_drop), 0);
    chk("rst_done", 32'(inval_done), 0);

    // 1: post-reset sweep, idx 0..7 on cycles 1..8, done+pred on cycle 9
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      step();
      chk("t1_sweep_en", 32'(wr_en), 1);
      chk("t1_sweep_idx", 32'(wr_idx), 32'(i));
    end
    step();
    chk("t1_done", 32'(inval_done), 1);
    chk("t1_pred", 32'(pred_en), 1);
    chk("t1_no_wr", 32'(wr_en), 0);

    // 2: bypass write
    upd_valid = 1'b1; upd_idx = 3'd5; upd_data = 17'h1ABCD;
    chk("t2_ready", 32'(upd_ready), 1);
    step();
    upd_valid = 1'b0;
    chk("t2_wr_en", 32'(wr_en), 1);
    chk("t2_wr_idx", 32'(wr_idx), 5);
    chk("t2_wr_data", 32'(wr_data), 32'h1ABCD);
    chk("t2_ready_after", 32'(upd_ready), 1);
    step();
    chk("t2_hold_idx", 32'(wr_idx), 5);

    // 3: five updates during a sweep, fifth held until drain starts
    base = log_q.size();
    inval_req = 1'b1; step(); inval_req = 1'b0;
    chk("t3_busy", 32'(inval_busy), 1);
    for (int i = 0; i < 4; i++) send(IDX_W'(i), 17'h00A10 + 17'(i));
    upd_valid = 1'b1; upd_idx = 3'd4; upd_data = 17'h00A14;
    chk("t3_full", 32'(upd_ready), 0);
    k = 0;
    while (upd_ready !== 1'b1 && k < 40) begin step(); k++; end
    chk("t3_ready_again", 32'(upd_ready), 1);
    step();
    upd_valid = 1'b0;
    k = 0;
    while (log_q.size() - base < 5 && k < 40) begin step(); k++; end
    chk("t3_nwrites", 32'(log_q.size() - base), 5);
    if (log_q.size() - base >= 5) begin
      chk("t3_first_after_done", 32'(log_cyc[base]), 32'(last_done_cyc + 1));
      for (int i = 0; i < 5; i++) begin
        chk("t3_order_idx", 32'(log_q[base+i].idx), 32'(i));
        chk("t3_order_data", 32'(log_q[base+i].data), 32'h00A10 + 32'(i));
        if (i > 0) chk("t3_consecutive", 32'(log_cyc[base+i] - log_cyc[base+i-1]), 1);
      end
    end
    repeat (3) step();

    // 4: invalidate with two entries still queued plus a same-cycle update
    base = log_q.size();
    inval_req = 1'b1; step(); inval_req = 1'b0;
    for (int i = 0; i < 4; i++) send(IDX_W'(4 + i), 17'h0B000 + 17'(i));
    wait_done("t4_done1");
    step(); step();
    inval_req = 1'b1; upd_valid = 1'b1; upd_idx = 3'd2; upd_data = 17'h1F00F;
    step();
    inval_req = 1'b0; upd_valid = 1'b0;
    chk("t4_drop", 32'(upd_drop), 1);
    chk("t4_busy", 32'(inval_busy), 1);
    wait_done("t4_done2");
    repeat (3) step();
    chk("t4_nwrites", 32'(log_q.size() - base), 2);
    if (log_q.size() - base >= 2) begin
      chk("t4_w0_idx", 32'(log_q[base].idx), 4);
      chk("t4_w0_data", 32'(log_q[base].data), 32'h0B000);
      chk("t4_w1_idx", 32'(log_q[base+1].idx), 5);
      chk("t4_w1_data", 32'(log_q[base+1].data), 32'h0B001);
    end

    // 5: invalidate mid-sweep is merged
    bdone = n_done; bzero = n_zero;
    inval_req = 1'b1; step(); inval_req = 1'b0;
    wait_wr_idx("t5_reach4", 3'd4);
    inval_req = 1'b1; step(); inval_req = 1'b0;
    wait_done("t5_done");
    repeat (3) step();
    chk("t5_one_done", 32'(n_done - bdone), 1);
    chk("t5_eight_zero_writes", 32'(n_zero - bzero), 8);

    // 6: reset mid-sweep with queued updates
    base = log_q.size();
    inval_req = 1'b1; step(); inval_req = 1'b0;
    for (int i = 0; i < 3; i++) send(IDX_W'(1 + i), 17'h0C000 + 17'(i));
    wait_wr_idx("t6_reach6", 3'd6);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_rst_wr_en", 32'(wr_en), 0);
    chk("t6_rst_busy", 32'(inval_busy), 1);
    chk("t6_rst_ready", 32'(upd_ready), 1);
    step();
    chk("t6_restart_en", 32'(wr_en), 1);
    chk("t6_restart_idx", 32'(wr_idx), 0);
    wait_done("t6_done");
    repeat (4) step();
    chk("t6_no_upd_writes", 32'(log_q.size() - base), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
